// File: rtl/exec_controller_if.sv
// Control/status bundle between the front panel, Control decode and the execution controller.
// The controller takes the slave view; the panel/decode side (or a bench) takes the master view.
interface exec_controller_if;
  logic       Enter;
  logic [1:0] freq;
  logic       step_mode;
  logic       Input;
  logic       Output;
  logic       Halt;
  logic       cpu_en;
  logic       io_ack;
  logic [1:0] state;
  logic       waiting;

  modport master (
    output Enter, freq, step_mode, Input, Output, Halt,
    input  cpu_en, io_ack, state, waiting
  );

  modport slave (
    input  Enter, freq, step_mode, Input, Output, Halt,
    output cpu_en, io_ack, state, waiting
  );
endinterface

// File: rtl/exec_controller.sv
// Execution controller: paces instruction commits from a programmable divider and the Enter
// button, handling IN waits, single-step mode and HALT. All outputs are registered.
module exec_controller #(
  parameter int DIV1 = 4,
  parameter int DIV2 = 16,
  parameter int DIV3 = 64
) (
  input  logic              CLK,
  input  logic              reset,
  exec_controller_if.slave  bus
);

  localparam logic [23:0] LIM1_M1 = 24'(DIV1 - 1);
  localparam logic [23:0] LIM2_M1 = 24'(DIV2 - 1);
  localparam logic [23:0] LIM3_M1 = 24'(DIV3 - 1);

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_WAIT_IN   = 2'b01,
    ST_STEP_WAIT = 2'b10,
    ST_HALTED    = 2'b11
  } state_e;

  state_e      state_r;
  state_e      state_nxt_s;
  logic        enter_s1_r;
  logic        enter_s2_r;
  logic        enter_s3_r;
  logic [1:0]  fill_r;
  logic        rise_s;
  logic [1:0]  freq_r;
  logic [23:0] cnt_r;
  logic [23:0] limit_m1_s;
  logic        tick_s;
  logic        cpu_en_nxt_s;
  logic        io_ack_nxt_s;
  logic        cpu_en_r;
  logic        io_ack_r;
  logic        waiting_r;
  logic        unused_output_s;

  // OUT needs no handshake: it commits like any ordinary instruction.
  assign unused_output_s = bus.Output;

  // Enter synchronizer and edge-detect pipeline
  always_ff @(posedge CLK) begin
    if (reset) begin
      enter_s1_r <= 1'b0;
      enter_s2_r <= 1'b0;
      enter_s3_r <= 1'b0;
      fill_r     <= 2'd0;
    end else begin
      enter_s1_r <= bus.Enter;
      enter_s2_r <= enter_s1_r;
      enter_s3_r <= enter_s2_r;
      if (fill_r != 2'd3) begin
        fill_r <= fill_r + 2'd1;
      end
    end
  end

  // Edges are only trusted once stage3 holds a real post-reset sample, so a button held
  // through reset release does not look like a fresh press.
  assign rise_s = enter_s2_r & ~enter_s3_r & (fill_r == 2'd3);

  // Divider limit for the registered rate select
  always_comb begin
    limit_m1_s = 24'd0;
    case (freq_r)
      2'b00:   limit_m1_s = 24'd0;
      2'b01:   limit_m1_s = LIM1_M1;
      2'b10:   limit_m1_s = LIM2_M1;
      2'b11:   limit_m1_s = LIM3_M1;
      default: limit_m1_s = 24'd0;
    endcase
  end

  assign tick_s = (freq_r == bus.freq) && (cnt_r >= limit_m1_s);

  // Next-state and commit decision
  always_comb begin
    state_nxt_s  = state_r;
    cpu_en_nxt_s = 1'b0;
    io_ack_nxt_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (tick_s) begin
          if (bus.Halt) begin
            state_nxt_s = ST_HALTED;
          end else if (bus.Input) begin
            state_nxt_s = ST_WAIT_IN;
          end else if (bus.step_mode) begin
            state_nxt_s = ST_STEP_WAIT;
          end else begin
            cpu_en_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_WAIT_IN: begin
        if (rise_s) begin
          cpu_en_nxt_s = 1'b1;
          io_ack_nxt_s = 1'b1;
          state_nxt_s  = bus.step_mode ? ST_STEP_WAIT : ST_RUN;
        end else begin
          state_nxt_s = ST_WAIT_IN;
        end
      end
      ST_STEP_WAIT: begin
        if (!bus.step_mode) begin
          state_nxt_s = ST_RUN;
        end else if (rise_s) begin
          // The press that reaches an IN only moves us to WAIT_IN; a second press commits it.
          if (bus.Halt) begin
            state_nxt_s = ST_HALTED;
          end else if (bus.Input) begin
            state_nxt_s = ST_WAIT_IN;
          end else begin
            cpu_en_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_STEP_WAIT;
        end
      end
      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Rate divider; restarts on a rate change or any state change
  always_ff @(posedge CLK) begin
    freq_r <= bus.freq;
    if (reset) begin
      cnt_r <= 24'd0;
    end else if ((bus.freq != freq_r) || (state_nxt_s != state_r) || tick_s) begin
      cnt_r <= 24'd0;
    end else begin
      cnt_r <= cnt_r + 24'd1;
    end
  end

  // State register and registered outputs
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r   <= ST_RUN;
      cpu_en_r  <= 1'b0;
      io_ack_r  <= 1'b0;
      waiting_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cpu_en_r  <= cpu_en_nxt_s;
      io_ack_r  <= io_ack_nxt_s;
      waiting_r <= (state_nxt_s == ST_WAIT_IN) || (state_nxt_s == ST_STEP_WAIT);
    end
  end

  assign bus.cpu_en  = cpu_en_r;
  assign bus.io_ack  = io_ack_r;
  assign bus.state   = state_r;
  assign bus.waiting = waiting_r;

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller: a per-cycle vector table plus hand-written
// multi-cycle sequences for divider timing, long waits and single-step counting.
module tb_exec_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  exec_controller_if bus();

  exec_controller #(.DIV1(4), .DIV2(16), .DIV3(64)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       enter;
    logic [1:0] freq;
    logic       step;
    logic       inp;
    logic       outp;
    logic       halt;
    logic       exp_en;
    logic       exp_ack;
    logic [1:0] exp_state;
    logic       exp_wait;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic [1:0] f, input logic s,
                     input logic i, input logic o, input logic h,
                     input logic xe, input logic xa, input logic [1:0] xs, input logic xw);
    vec_t v;
    v.rst = r; v.enter = e; v.freq = f; v.step = s; v.inp = i; v.outp = o; v.halt = h;
    v.exp_en = xe; v.exp_ack = xa; v.exp_state = xs; v.exp_wait = xw;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] f, input logic s,
                       input logic i, input logic h);
    reset = r; bus.Enter = e; bus.freq = f; bus.step_mode = s; bus.Input = i; bus.Halt = h;
    bus.Output = 1'b0;
  endtask

  int cnt_en;
  int consec;
  logic prev_en;

  initial begin
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    //  rst en  freq  st  in  out hlt | en  ack state  wait
    add(1, 0, 2'b00, 0, 0, 0, 0,   0, 0, 2'b00, 0);  // v0 reset
    add(0, 0, 2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0);  // v1 freq00 commits every cycle
    add(0, 0, 2'b00, 0, 0, 1, 0,   1, 0, 2'b00, 0);  // v2 OUT commits without wait
    add(0, 0, 2'b00, 0, 1, 0, 0,   0, 0, 2'b01, 1);  // v3 IN -> WAIT_IN
    add(0, 0, 2'b00, 0, 1, 0, 0,   0, 0, 2'b01, 1);  // v4
    add(0, 1, 2'b00, 0, 1, 0, 0,   0, 0, 2'b01, 1);  // v5 Enter first sampled (k)
    add(0, 0, 2'b00, 0, 1, 0, 0,   0, 0, 2'b01, 1);  // v6 k+1
    add(0, 0, 2'b00, 0, 0, 0, 0,   1, 1, 2'b00, 0);  // v7 k+2 commit IN
    add(0, 0, 2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0);  // v8
    add(0, 0, 2'b00, 0, 1, 0, 1,   0, 0, 2'b11, 0);  // v9 Halt beats Input
    add(0, 1, 2'b11, 0, 0, 0, 0,   0, 0, 2'b11, 0);  // v10 halted ignores all
    add(0, 0, 2'b11, 0, 0, 0, 0,   0, 0, 2'b11, 0);  // v11
    add(0, 0, 2'b11, 0, 0, 0, 0,   0, 0, 2'b11, 0);  // v12
    add(0, 0, 2'b01, 1, 0, 0, 0,   0, 0, 2'b11, 0);  // v13
    add(1, 0, 2'b00, 0, 0, 0, 0,   0, 0, 2'b00, 0);  // v14 reset exits HALTED
    add(0, 0, 2'b00, 0, 1, 0, 0,   0, 0, 2'b01, 1);  // v15 WAIT_IN
    add(0, 1, 2'b00, 0, 1, 0, 0,   0, 0, 2'b01, 1);  // v16 Enter sampled
    add(0, 0, 2'b00, 0, 1, 0, 0,   0, 0, 2'b01, 1);  // v17 rise pending
    add(1, 0, 2'b00, 0, 1, 0, 0,   0, 0, 2'b00, 0);  // v18 reset beats rise
    add(0, 0, 2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0);  // v19
    add(0, 0, 2'b00, 1, 0, 0, 0,   0, 0, 2'b10, 1);  // v20 step mode
    add(0, 0, 2'b00, 1, 0, 0, 0,   0, 0, 2'b10, 1);  // v21
    add(0, 1, 2'b00, 1, 0, 0, 0,   0, 0, 2'b10, 1);  // v22 press
    add(0, 0, 2'b00, 1, 0, 0, 0,   0, 0, 2'b10, 1);  // v23
    add(0, 0, 2'b00, 1, 0, 0, 0,   1, 0, 2'b10, 1);  // v24 step commit
    add(0, 0, 2'b00, 1, 0, 0, 0,   0, 0, 2'b10, 1);  // v25
    add(0, 1, 2'b00, 1, 1, 0, 0,   0, 0, 2'b10, 1);  // v26 press on IN
    add(0, 0, 2'b00, 1, 1, 0, 0,   0, 0, 2'b10, 1);  // v27
    add(0, 0, 2'b00, 1, 1, 0, 0,   0, 0, 2'b01, 1);  // v28 -> WAIT_IN, no commit
    add(0, 1, 2'b00, 1, 1, 0, 0,   0, 0, 2'b01, 1);  // v29 second press
    add(0, 0, 2'b00, 1, 1, 0, 0,   0, 0, 2'b01, 1);  // v30
    add(0, 0, 2'b00, 1, 1, 0, 0,   1, 1, 2'b10, 1);  // v31 IN commit, back to STEP_WAIT
    add(0, 0, 2'b00, 0, 0, 0, 0,   0, 0, 2'b00, 0);  // v32 step off -> RUN
    add(0, 0, 2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0);  // v33
    add(0, 0, 2'b00, 1, 0, 0, 0,   0, 0, 2'b10, 1);  // v34
    add(0, 1, 2'b00, 1, 0, 0, 1,   0, 0, 2'b10, 1);  // v35 press on HALT
    add(0, 0, 2'b00, 1, 0, 0, 1,   0, 0, 2'b10, 1);  // v36
    add(0, 0, 2'b00, 1, 0, 0, 1,   0, 0, 2'b11, 0);  // v37 -> HALTED
    add(1, 0, 2'b00, 0, 0, 0, 0,   0, 0, 2'b00, 0);  // v38
    add(1, 1, 2'b00, 0, 0, 0, 0,   0, 0, 2'b00, 0);  // v39 Enter held through reset
    add(0, 1, 2'b00, 1, 0, 0, 0,   0, 0, 2'b10, 1);  // v40
    add(0, 1, 2'b00, 1, 0, 0, 0,   0, 0, 2'b10, 1);  // v41
    add(0, 1, 2'b00, 1, 0, 0, 0,   0, 0, 2'b10, 1);  // v42 no spurious rise
    add(0, 1, 2'b00, 1, 0, 0, 0,   0, 0, 2'b10, 1);  // v43
    add(1, 0, 2'b00, 0, 0, 0, 0,   0, 0, 2'b00, 0);  // v44

    foreach (vq[i]) begin
      reset = vq[i].rst; bus.Enter = vq[i].enter; bus.freq = vq[i].freq;
      bus.step_mode = vq[i].step; bus.Input = vq[i].inp; bus.Output = vq[i].outp;
      bus.Halt = vq[i].halt;
      cyc();
      chk($sformatf("v%0d cpu_en", i), 32'(bus.cpu_en), 32'(vq[i].exp_en));
      chk($sformatf("v%0d io_ack", i), 32'(bus.io_ack), 32'(vq[i].exp_ack));
      chk($sformatf("v%0d state", i), 32'(bus.state), 32'(vq[i].exp_state));
      chk($sformatf("v%0d waiting", i), 32'(bus.waiting), 32'(vq[i].exp_wait));
    end

    // freq=00: a commit on each of 20 consecutive cycles
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      chk($sformatf("f00 cpu_en c%0d", n), 32'(bus.cpu_en), 32'd1);
      chk($sformatf("f00 state c%0d", n), 32'(bus.state), 32'd0);
    end

    // freq=01 cadence, then switch to freq=10 mid-count; a RUN press is dropped
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      chk($sformatf("f01 cpu_en c%0d", n), 32'(bus.cpu_en), 32'((n % 4) == 0));
    end
    bus.freq = 2'b10;
    for (int m = 1; m <= 33; m++) begin
      bus.Enter = (m == 3) ? 1'b1 : 1'b0;
      cyc();
      chk($sformatf("f10 cpu_en c%0d", m), 32'(bus.cpu_en), 32'((m == 17) || (m == 33)));
      chk($sformatf("f10 state c%0d", m), 32'(bus.state), 32'd0);
    end

    // Long IN wait, then a single press commits exactly once
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;
    bus.Input = 1'b1;
    cyc();
    chk("in state", 32'(bus.state), 32'd1);
    chk("in waiting", 32'(bus.waiting), 32'd1);
    bus.freq = 2'b11;
    cnt_en = 0;
    for (int n = 0; n < 100; n++) begin
      cyc();
      cnt_en += int'(bus.cpu_en);
    end
    chk("in idle commits", 32'(cnt_en), 32'd0);
    bus.Enter = 1'b1;
    cyc();
    chk("in k cpu_en", 32'(bus.cpu_en), 32'd0);
    bus.Enter = 1'b0;
    cyc();
    chk("in k+1 cpu_en", 32'(bus.cpu_en), 32'd0);
    cyc();
    chk("in k+2 cpu_en", 32'(bus.cpu_en), 32'd1);
    chk("in k+2 io_ack", 32'(bus.io_ack), 32'd1);
    chk("in k+2 state", 32'(bus.state), 32'd0);
    chk("in k+2 waiting", 32'(bus.waiting), 32'd0);
    bus.Input = 1'b0;
    cyc();
    chk("in k+3 cpu_en", 32'(bus.cpu_en), 32'd0);
    chk("in k+3 io_ack", 32'(bus.io_ack), 32'd0);

    // Single-step: three presses (first held 50 cycles) give three commits
    drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;
    cnt_en = 0;
    consec = 0;
    prev_en = 1'b0;
    for (int c = 0; c < 120; c++) begin
      bus.Enter = ((c >= 5) && (c < 55)) || ((c >= 70) && (c < 72)) || ((c >= 90) && (c < 92));
      cyc();
      cnt_en += int'(bus.cpu_en);
      if (prev_en && bus.cpu_en) begin
        consec++;
      end
      prev_en = bus.cpu_en;
    end
    chk("step commits", 32'(cnt_en), 32'd3);
    chk("step back-to-back", 32'(consec), 32'd0);
    chk("step state", 32'(bus.state), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
